mips_exec_ctrl_unit: RTL and testbench

//  Combined instruction decoder, ALU-op decoder and 32-bit ALU with internal HI/LO registers for a single-cycle MIPS-I core.

---
 rtl/mips_exec_ctrl_unit_if.sv | 36 +++
 rtl/mips_exec_ctrl_unit.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mips_exec_ctrl_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mips_exec_ctrl_unit_if.sv
// Instruction/operand inputs and decode/ALU/HI-LO outputs of the MIPS-I execute control unit.
// The master side supplies the instruction and operands; the slave side is the execute unit.
interface mips_exec_ctrl_unit_if;
    logic        clk_enable;
    logic [31:0] instr;
    logic [31:0] reg_data_a;
    logic [31:0] reg_data_b;
    logic [1:0]  pc_sel;
    logic        reg_write_enable;
    logic [1:0]  reg_addr_sel;
    logic [1:0]  reg_data_sel;
    logic        signextend_sel;
    logic [1:0]  lwlr_sel;
    logic        data_read;
    logic        data_write;
    logic [3:0]  byte_enable;
    logic [31:0] alu_result;
    logic [1:0]  byte_offset;
    logic        branch_cond_true;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output clk_enable, instr, reg_data_a, reg_data_b,
        input  pc_sel, reg_write_enable, reg_addr_sel, reg_data_sel, signextend_sel,
               lwlr_sel, data_read, data_write, byte_enable, alu_result, byte_offset,
               branch_cond_true, hi, lo
    );

    modport slave (
        input  clk_enable, instr, reg_data_a, reg_data_b,
        output pc_sel, reg_write_enable, reg_addr_sel, reg_data_sel, signextend_sel,
               lwlr_sel, data_read, data_write, byte_enable, alu_result, byte_offset,
               branch_cond_true, hi, lo
    );
endinterface

// File: rtl/mips_exec_ctrl_unit.sv
// Single-cycle MIPS-I execute control: instruction decode, ALU, branch compare and HI/LO.
// Everything except HI/LO is combinational; write strobes are masked by clk_enable and reset.
module mips_exec_ctrl_unit (
    input logic                  clk,
    input logic                  reset,
    mips_exec_ctrl_unit_if.slave bus
);
    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
        ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO
    } alu_op_t;

    typedef enum logic [2:0] {
        HL_NONE, HL_MULT, HL_MULTU, HL_DIV, HL_DIVU, HL_MTHI, HL_MTLO
    } hilo_op_t;

    typedef enum logic [1:0] {MEM_WORD, MEM_HALF, MEM_BYTE} mem_size_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL  = 6'h22, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_LWR  = 6'h26;
    localparam logic [5:0] OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU  = 6'h23, FN_AND  = 6'h24, FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;

    // Byte-lane mask for a memory access of the given size at the given word offset.
    function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            MEM_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
            MEM_BYTE: mask = 4'b0001 << off;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rt_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;
    logic [31:0] a_s;
    logic [31:0] b_s;

    assign opcode_s = bus.instr[31:26];
    assign rt_s     = bus.instr[20:16];
    assign shamt_s  = bus.instr[10:6];
    assign funct_s  = bus.instr[5:0];
    assign imm_s    = bus.instr[15:0];
    assign a_s      = bus.reg_data_a;
    assign b_s      = bus.reg_data_b;

    logic [1:0] pc_sel_s;
    logic       wr_s;
    logic [1:0] addr_sel_s;
    logic [1:0] data_sel_s;
    logic       sext_sel_s;
    logic [1:0] lwlr_sel_s;
    logic       mem_rd_s;
    logic       mem_wr_s;
    mem_size_t  mem_size_s;
    logic       use_imm_s;
    logic       imm_sext_s;
    logic       shamt_var_s;
    logic       branch_s;
    alu_op_t    alu_op_s;
    hilo_op_t   hilo_op_s;

    logic [31:0] hi_r;
    logic [31:0] lo_r;

    // Instruction decode: datapath selects, strobes and ALU / HI-LO operation.
    always_comb begin
        pc_sel_s    = 2'b00;
        wr_s        = 1'b0;
        addr_sel_s  = 2'b00;
        data_sel_s  = 2'b00;
        sext_sel_s  = 1'b0;
        lwlr_sel_s  = 2'b00;
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_size_s  = MEM_WORD;
        use_imm_s   = 1'b0;
        imm_sext_s  = 1'b0;
        shamt_var_s = 1'b0;
        branch_s    = 1'b0;
        alu_op_s    = ALU_NONE;
        hilo_op_s   = HL_NONE;
        // The canonical NOP encoding (SLL r0,r0,0) is kept strobe-free.
        if (bus.instr == 32'h0000_0000) begin
            alu_op_s = ALU_NONE;
        end else begin
            case (opcode_s)
                OP_SPECIAL: begin
                    case (funct_s)
                        FN_SLL:   begin alu_op_s = ALU_SLL;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_SRL:   begin alu_op_s = ALU_SRL;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_SRA:   begin alu_op_s = ALU_SRA;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_SLLV:  begin alu_op_s = ALU_SLL;  wr_s = 1'b1; addr_sel_s = 2'b01; shamt_var_s = 1'b1; end
                        FN_SRLV:  begin alu_op_s = ALU_SRL;  wr_s = 1'b1; addr_sel_s = 2'b01; shamt_var_s = 1'b1; end
                        FN_SRAV:  begin alu_op_s = ALU_SRA;  wr_s = 1'b1; addr_sel_s = 2'b01; shamt_var_s = 1'b1; end
                        FN_JR:    begin pc_sel_s = 2'b11; end
                        FN_JALR:  begin pc_sel_s = 2'b11; wr_s = 1'b1; addr_sel_s = 2'b01; data_sel_s = 2'b11; end
                        FN_MFHI:  begin alu_op_s = ALU_MFHI; wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_MFLO:  begin alu_op_s = ALU_MFLO; wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_MTHI:  begin hilo_op_s = HL_MTHI; end
                        FN_MTLO:  begin hilo_op_s = HL_MTLO; end
                        FN_MULT:  begin hilo_op_s = HL_MULT; end
                        FN_MULTU: begin hilo_op_s = HL_MULTU; end
                        FN_DIV:   begin hilo_op_s = HL_DIV; end
                        FN_DIVU:  begin hilo_op_s = HL_DIVU; end
                        FN_ADDU:  begin alu_op_s = ALU_ADD;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_SUBU:  begin alu_op_s = ALU_SUB;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_AND:   begin alu_op_s = ALU_AND;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_OR:    begin alu_op_s = ALU_OR;   wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_XOR:   begin alu_op_s = ALU_XOR;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_SLT:   begin alu_op_s = ALU_SLT;  wr_s = 1'b1; addr_sel_s = 2'b01; end
                        FN_SLTU:  begin alu_op_s = ALU_SLTU; wr_s = 1'b1; addr_sel_s = 2'b01; end
                        default:  begin alu_op_s = ALU_NONE; end
                    endcase
                end
                OP_REGIMM: begin
                    case (rt_s)
                        5'b00000, 5'b00001: begin pc_sel_s = 2'b01; branch_s = 1'b1; end
                        // BLTZAL/BGEZAL link r31 whether or not the branch is taken.
                        5'b10000, 5'b10001: begin
                            pc_sel_s = 2'b01; branch_s = 1'b1;
                            wr_s = 1'b1; addr_sel_s = 2'b10; data_sel_s = 2'b11;
                        end
                        default: begin branch_s = 1'b0; end
                    endcase
                end
                OP_J:    begin pc_sel_s = 2'b10; end
                OP_JAL:  begin pc_sel_s = 2'b10; wr_s = 1'b1; addr_sel_s = 2'b10; data_sel_s = 2'b11; end
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin pc_sel_s = 2'b01; branch_s = 1'b1; end
                OP_ADDIU: begin alu_op_s = ALU_ADD;  wr_s = 1'b1; use_imm_s = 1'b1; imm_sext_s = 1'b1; sext_sel_s = 1'b1; end
                OP_SLTI:  begin alu_op_s = ALU_SLT;  wr_s = 1'b1; use_imm_s = 1'b1; imm_sext_s = 1'b1; sext_sel_s = 1'b1; end
                OP_SLTIU: begin alu_op_s = ALU_SLTU; wr_s = 1'b1; use_imm_s = 1'b1; imm_sext_s = 1'b1; sext_sel_s = 1'b1; end
                OP_ANDI:  begin alu_op_s = ALU_AND;  wr_s = 1'b1; use_imm_s = 1'b1; end
                OP_ORI:   begin alu_op_s = ALU_OR;   wr_s = 1'b1; use_imm_s = 1'b1; end
                OP_XORI:  begin alu_op_s = ALU_XOR;  wr_s = 1'b1; use_imm_s = 1'b1; end
                OP_LUI:   begin alu_op_s = ALU_LUI;  wr_s = 1'b1; use_imm_s = 1'b1; end
                OP_LB, OP_LH, OP_LBU, OP_LHU, OP_LW, OP_LWL, OP_LWR: begin
                    alu_op_s = ALU_ADD; use_imm_s = 1'b1; imm_sext_s = 1'b1;
                    mem_rd_s = 1'b1; wr_s = 1'b1;
                    sext_sel_s = (opcode_s != OP_LBU) && (opcode_s != OP_LHU);
                    case (opcode_s)
                        OP_LB, OP_LBU: begin mem_size_s = MEM_BYTE; data_sel_s = 2'b10; end
                        OP_LH, OP_LHU: begin mem_size_s = MEM_HALF; data_sel_s = 2'b10; end
                        OP_LWL:        begin data_sel_s = 2'b01; lwlr_sel_s = 2'b11; end
                        OP_LWR:        begin data_sel_s = 2'b01; lwlr_sel_s = 2'b10; end
                        default:       begin data_sel_s = 2'b01; end
                    endcase
                end
                OP_SB, OP_SH, OP_SW: begin
                    alu_op_s = ALU_ADD; use_imm_s = 1'b1; imm_sext_s = 1'b1; sext_sel_s = 1'b1;
                    mem_wr_s = 1'b1;
                    case (opcode_s)
                        OP_SB:   mem_size_s = MEM_BYTE;
                        OP_SH:   mem_size_s = MEM_HALF;
                        default: mem_size_s = MEM_WORD;
                    endcase
                end
                default: begin alu_op_s = ALU_NONE; end
            endcase
        end
    end

    logic [31:0] op_b_s;
    logic [4:0]  sh_amt_s;
    logic [31:0] alu_s;

    // Operand B selection and the ALU proper.
    always_comb begin
        if (use_imm_s) begin
            op_b_s = imm_sext_s ? {{16{imm_s[15]}}, imm_s} : {16'h0000, imm_s};
        end else begin
            op_b_s = b_s;
        end
        sh_amt_s = shamt_var_s ? a_s[4:0] : shamt_s;
        case (alu_op_s)
            ALU_ADD:  alu_s = a_s + op_b_s;
            ALU_SUB:  alu_s = a_s - op_b_s;
            ALU_AND:  alu_s = a_s & op_b_s;
            ALU_OR:   alu_s = a_s | op_b_s;
            ALU_XOR:  alu_s = a_s ^ op_b_s;
            ALU_SLT:  alu_s = {31'h0, ($signed(a_s) < $signed(op_b_s))};
            ALU_SLTU: alu_s = {31'h0, (a_s < op_b_s)};
            ALU_LUI:  alu_s = {imm_s, 16'h0000};
            ALU_SLL:  alu_s = op_b_s << sh_amt_s;
            ALU_SRL:  alu_s = op_b_s >> sh_amt_s;
            ALU_SRA:  alu_s = 32'($signed(op_b_s) >>> sh_amt_s);
            ALU_MFHI: alu_s = hi_r;
            ALU_MFLO: alu_s = lo_r;
            default:  alu_s = 32'h0000_0000;
        endcase
    end

    logic cmp_s;

    // Branch comparison; only meaningful when the decoder flags a branch.
    always_comb begin
        case (opcode_s)
            OP_BEQ:    cmp_s = (a_s == b_s);
            OP_BNE:    cmp_s = (a_s != b_s);
            OP_BLEZ:   cmp_s = a_s[31] | (a_s == 32'h0000_0000);
            OP_BGTZ:   cmp_s = ~a_s[31] & (a_s != 32'h0000_0000);
            OP_REGIMM: cmp_s = rt_s[0] ? ~a_s[31] : a_s[31];
            default:   cmp_s = 1'b0;
        endcase
    end

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic [31:0] quot_signed_s;
    logic [31:0] rem_signed_s;
    logic [31:0] quot_unsigned_s;
    logic [31:0] rem_unsigned_s;
    logic        div_zero_s;

    assign prod_signed_s   = 64'($signed({{32{a_s[31]}}, a_s}) * $signed({{32{b_s[31]}}, b_s}));
    assign prod_unsigned_s = {32'h0000_0000, a_s} * {32'h0000_0000, b_s};
    assign div_zero_s      = (b_s == 32'h0000_0000);
    assign quot_signed_s   = div_zero_s ? 32'h0000_0000 : 32'($signed(a_s) / $signed(b_s));
    assign rem_signed_s    = div_zero_s ? 32'h0000_0000 : 32'($signed(a_s) % $signed(b_s));
    assign quot_unsigned_s = div_zero_s ? 32'h0000_0000 : a_s / b_s;
    assign rem_unsigned_s  = div_zero_s ? 32'h0000_0000 : a_s % b_s;

    // HI/LO register update; a zero divisor leaves both untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= 32'h0000_0000;
            lo_r <= 32'h0000_0000;
        end else if (bus.clk_enable) begin
            case (hilo_op_s)
                HL_MULT:  begin hi_r <= prod_signed_s[63:32];   lo_r <= prod_signed_s[31:0];   end
                HL_MULTU: begin hi_r <= prod_unsigned_s[63:32]; lo_r <= prod_unsigned_s[31:0]; end
                HL_DIV:   if (!div_zero_s) begin hi_r <= rem_signed_s;   lo_r <= quot_signed_s;   end
                HL_DIVU:  if (!div_zero_s) begin hi_r <= rem_unsigned_s; lo_r <= quot_unsigned_s; end
                HL_MTHI:  hi_r <= a_s;
                HL_MTLO:  lo_r <= a_s;
                default:  begin hi_r <= hi_r; lo_r <= lo_r; end
            endcase
        end
    end

    logic en_s;
    assign en_s = bus.clk_enable & reset;

    // Drive the bus outputs; write strobes are qualified, decode selects are not.
    always_comb begin
        bus.pc_sel           = pc_sel_s;
        bus.reg_write_enable = wr_s & en_s;
        bus.reg_addr_sel     = addr_sel_s;
        bus.reg_data_sel     = data_sel_s;
        bus.signextend_sel   = sext_sel_s;
        bus.lwlr_sel         = lwlr_sel_s;
        bus.data_read        = mem_rd_s & en_s;
        bus.data_write       = mem_wr_s & en_s;
        bus.byte_enable      = lane_mask(mem_size_s, alu_s[1:0]);
        bus.alu_result       = alu_s;
        bus.byte_offset      = alu_s[1:0];
        bus.branch_cond_true = branch_s & cmp_s;
        bus.hi               = hi_r;
        bus.lo               = lo_r;
    end
endmodule

// File: tb/tb_mips_exec_ctrl_unit.sv
// Directed self-checking bench for mips_exec_ctrl_unit with hand-computed expectations.
module tb_mips_exec_ctrl_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    mips_exec_ctrl_unit_if bus();

    mips_exec_ctrl_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        bus.instr = i; bus.reg_data_a = a; bus.reg_data_b = b;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; #2; reset = 1'b0;
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h1, 32'h2);
        n_cmp++; if (bus.hi !== 32'h0) begin $display("FAIL reset_hi got %h want %h", bus.hi, 32'h0); n_fail++; end
        n_cmp++; if (bus.lo !== 32'h0) begin $display("FAIL reset_lo got %h want %h", bus.lo, 32'h0); n_fail++; end
        n_cmp++; if (bus.reg_write_enable !== 1'b0) begin $display("FAIL reset_we got %b want 0", bus.reg_write_enable); n_fail++; end
        n_cmp++; if (bus.reg_addr_sel !== 2'b01) begin $display("FAIL reset_addr_sel got %b want 01", bus.reg_addr_sel); n_fail++; end
        reset = 1'b1; #1;
        n_cmp++; if (bus.reg_write_enable !== 1'b1) begin $display("FAIL release_we got %b want 1", bus.reg_write_enable); n_fail++; end
    endtask

    task automatic test_alu;
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'hFFFF_FFFF, 32'h1);
        n_cmp++; if (bus.alu_result !== 32'h0) begin $display("FAIL addu_wrap got %h want %h", bus.alu_result, 32'h0); n_fail++; end
        n_cmp++; if (bus.reg_data_sel !== 2'b00 || bus.pc_sel !== 2'b00) begin $display("FAIL addu_sels got %b/%b want 00/00", bus.reg_data_sel, bus.pc_sel); n_fail++; end
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 32'h5, 32'h7);
        n_cmp++; if (bus.alu_result !== 32'hFFFF_FFFE) begin $display("FAIL subu got %h want %h", bus.alu_result, 32'hFFFF_FFFE); n_fail++; end
        drive(i_type(6'h0C, 5'd2, 16'hFF00), 32'hF0F0_1234, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'h0000_1200) begin $display("FAIL andi got %h want %h", bus.alu_result, 32'h0000_1200); n_fail++; end
        n_cmp++; if (bus.signextend_sel !== 1'b0 || bus.reg_addr_sel !== 2'b00) begin $display("FAIL andi_sels got %b/%b want 0/00", bus.signextend_sel, bus.reg_addr_sel); n_fail++; end
        drive(i_type(6'h0D, 5'd2, 16'h8001), 32'h1234_0000, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'h1234_8001) begin $display("FAIL ori got %h want %h", bus.alu_result, 32'h1234_8001); n_fail++; end
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h26), 32'hFFFF_0000, 32'h0F0F_0F0F);
        n_cmp++; if (bus.alu_result !== 32'hF0F0_0F0F) begin $display("FAIL xor got %h want %h", bus.alu_result, 32'hF0F0_0F0F); n_fail++; end
        drive(i_type(6'h09, 5'd2, 16'hFFFF), 32'h10, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'hF || bus.signextend_sel !== 1'b1) begin $display("FAIL addiu got %h/%b want f/1", bus.alu_result, bus.signextend_sel); n_fail++; end
        drive(i_type(6'h0F, 5'd2, 16'hABCD), 32'h1, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'hABCD_0000 || bus.reg_write_enable !== 1'b1) begin $display("FAIL lui got %h/%b want abcd0000/1", bus.alu_result, bus.reg_write_enable); n_fail++; end
    endtask

    task automatic test_shift_slt;
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'h1);
        n_cmp++; if (bus.alu_result !== 32'h1) begin $display("FAIL slt got %h want 1", bus.alu_result); n_fail++; end
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'hFFFF_FFFF, 32'h1);
        n_cmp++; if (bus.alu_result !== 32'h0) begin $display("FAIL sltu got %h want 0", bus.alu_result); n_fail++; end
        drive(i_type(6'h0A, 5'd2, 16'hFFFF), 32'h5, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'h0) begin $display("FAIL slti got %h want 0", bus.alu_result); n_fail++; end
        drive(i_type(6'h0B, 5'd2, 16'hFFFF), 32'h5, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'h1) begin $display("FAIL sltiu got %h want 1", bus.alu_result); n_fail++; end
        drive(r_type(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 32'h0, 32'h8000_0000);
        n_cmp++; if (bus.alu_result !== 32'hF800_0000) begin $display("FAIL sra got %h want %h", bus.alu_result, 32'hF800_0000); n_fail++; end
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h06), 32'h8, 32'hF000_0000);
        n_cmp++; if (bus.alu_result !== 32'h00F0_0000) begin $display("FAIL srlv got %h want %h", bus.alu_result, 32'h00F0_0000); n_fail++; end
        drive(r_type(5'd0, 5'd2, 5'd3, 5'd31, 6'h00), 32'h0, 32'h1);
        n_cmp++; if (bus.alu_result !== 32'h8000_0000) begin $display("FAIL sll31 got %h want %h", bus.alu_result, 32'h8000_0000); n_fail++; end
    endtask

    task automatic test_mult_div;
        @(negedge clk); drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 32'hFFFF_FFFE, 32'h3);
        @(posedge clk); #1;
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin $display("FAIL mult got %h:%h want ffffffff:fffffffa", bus.hi, bus.lo); n_fail++; end
        drive(r_type(5'd0, 5'd0, 5'd3, 5'd0, 6'h10), 32'h0, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'hFFFF_FFFF || bus.reg_addr_sel !== 2'b01) begin $display("FAIL mfhi got %h/%b want ffffffff/01", bus.alu_result, bus.reg_addr_sel); n_fail++; end
        drive(r_type(5'd0, 5'd0, 5'd3, 5'd0, 6'h12), 32'h0, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'hFFFF_FFFA) begin $display("FAIL mflo got %h want fffffffa", bus.alu_result); n_fail++; end
        @(negedge clk); drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h1A), 32'hFFFF_FFF9, 32'h2);
        @(posedge clk); #1;
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin $display("FAIL div got hi %h lo %h want ffffffff fffffffd", bus.hi, bus.lo); n_fail++; end
        @(negedge clk); drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h1A), 32'h5, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin $display("FAIL div0 got hi %h lo %h want ffffffff fffffffd", bus.hi, bus.lo); n_fail++; end
        @(negedge clk); drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h1B), 32'h7, 32'h2);
        @(posedge clk); #1;
        n_cmp++; if (bus.lo !== 32'h3 || bus.hi !== 32'h1) begin $display("FAIL divu got hi %h lo %h want 1 3", bus.hi, bus.lo); n_fail++; end
        @(negedge clk); drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h19), 32'hFFFF_FFFF, 32'h2);
        @(posedge clk); #1;
        n_cmp++; if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin $display("FAIL multu got %h:%h want 1:fffffffe", bus.hi, bus.lo); n_fail++; end
        @(negedge clk); drive(r_type(5'd1, 5'd0, 5'd0, 5'd0, 6'h11), 32'h1234, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if (bus.hi !== 32'h1234 || bus.lo !== 32'hFFFF_FFFE) begin $display("FAIL mthi got %h:%h want 1234:fffffffe", bus.hi, bus.lo); n_fail++; end
        drive(32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_branch;
        drive(i_type(6'h04, 5'd2, 16'h0010), 32'h7, 32'h7);
        n_cmp++; if (bus.pc_sel !== 2'b01 || bus.branch_cond_true !== 1'b1 || bus.reg_write_enable !== 1'b0) begin $display("FAIL beq got pc %b cond %b we %b want 01 1 0", bus.pc_sel, bus.branch_cond_true, bus.reg_write_enable); n_fail++; end
        drive(i_type(6'h05, 5'd2, 16'h0010), 32'h7, 32'h7);
        n_cmp++; if (bus.branch_cond_true !== 1'b0) begin $display("FAIL bne_eq got %b want 0", bus.branch_cond_true); n_fail++; end
        drive(i_type(6'h06, 5'd0, 16'h0010), 32'h0, 32'h0);
        n_cmp++; if (bus.branch_cond_true !== 1'b1) begin $display("FAIL blez_zero got %b want 1", bus.branch_cond_true); n_fail++; end
        drive(i_type(6'h07, 5'd0, 16'h0010), 32'h0, 32'h0);
        n_cmp++; if (bus.branch_cond_true !== 1'b0) begin $display("FAIL bgtz_zero got %b want 0", bus.branch_cond_true); n_fail++; end
        drive(i_type(6'h01, 5'd0, 16'h0010), 32'hFFFF_FFFF, 32'h0);
        n_cmp++; if (bus.branch_cond_true !== 1'b1) begin $display("FAIL bltz_neg got %b want 1", bus.branch_cond_true); n_fail++; end
        drive(i_type(6'h01, 5'd17, 16'h0010), 32'hFFFF_FFFF, 32'h0);
        n_cmp++; if (bus.branch_cond_true !== 1'b0 || bus.reg_write_enable !== 1'b1 || bus.reg_data_sel !== 2'b11 || bus.reg_addr_sel[1] !== 1'b1) begin
            $display("FAIL bgezal got cond %b we %b dsel %b asel %b want 0 1 11 1x", bus.branch_cond_true, bus.reg_write_enable, bus.reg_data_sel, bus.reg_addr_sel); n_fail++; end
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h7, 32'h7);
        n_cmp++; if (bus.branch_cond_true !== 1'b0) begin $display("FAIL nonbranch_cond got %b want 0", bus.branch_cond_true); n_fail++; end
    endtask

    task automatic test_jump;
        drive({6'h02, 26'h0000100}, 32'h0, 32'h0);
        n_cmp++; if (bus.pc_sel !== 2'b10 || bus.reg_write_enable !== 1'b0) begin $display("FAIL j got pc %b we %b want 10 0", bus.pc_sel, bus.reg_write_enable); n_fail++; end
        drive({6'h03, 26'h0000100}, 32'h0, 32'h0);
        n_cmp++; if (bus.pc_sel !== 2'b10 || bus.reg_write_enable !== 1'b1 || bus.reg_addr_sel[1] !== 1'b1 || bus.reg_data_sel !== 2'b11) begin
            $display("FAIL jal got pc %b we %b asel %b dsel %b want 10 1 1x 11", bus.pc_sel, bus.reg_write_enable, bus.reg_addr_sel, bus.reg_data_sel); n_fail++; end
        drive(r_type(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 32'h400, 32'h0);
        n_cmp++; if (bus.pc_sel !== 2'b11 || bus.reg_write_enable !== 1'b0) begin $display("FAIL jr got pc %b we %b want 11 0", bus.pc_sel, bus.reg_write_enable); n_fail++; end
        drive(r_type(5'd1, 5'd0, 5'd5, 5'd0, 6'h09), 32'h400, 32'h0);
        n_cmp++; if (bus.pc_sel !== 2'b11 || bus.reg_write_enable !== 1'b1 || bus.reg_addr_sel !== 2'b01 || bus.reg_data_sel !== 2'b11) begin
            $display("FAIL jalr got pc %b we %b asel %b dsel %b want 11 1 01 11", bus.pc_sel, bus.reg_write_enable, bus.reg_addr_sel, bus.reg_data_sel); n_fail++; end
        drive({6'h3F, 26'h3FF_FFFF}, 32'h1, 32'h1);
        n_cmp++; if (bus.reg_write_enable !== 1'b0 || bus.data_read !== 1'b0 || bus.data_write !== 1'b0 || bus.pc_sel !== 2'b00) begin $display("FAIL unknown_op got strobes %b%b%b pc %b want 000 00", bus.reg_write_enable, bus.data_read, bus.data_write, bus.pc_sel); n_fail++; end
        drive(32'h0, 32'h1, 32'h1);
        n_cmp++; if (bus.reg_write_enable !== 1'b0 || bus.pc_sel !== 2'b00) begin $display("FAIL nop got we %b pc %b want 0 00", bus.reg_write_enable, bus.pc_sel); n_fail++; end
    endtask

    task automatic test_mem;
        drive(i_type(6'h29, 5'd2, 16'h0002), 32'h1000, 32'hBEEF);
        n_cmp++; if (bus.alu_result !== 32'h1002 || bus.byte_offset !== 2'b10) begin $display("FAIL sh_addr got %h off %b want 1002 10", bus.alu_result, bus.byte_offset); n_fail++; end
        n_cmp++; if (bus.byte_enable !== 4'b1100 || bus.data_write !== 1'b1 || bus.reg_write_enable !== 1'b0 || bus.data_read !== 1'b0) begin
            $display("FAIL sh_strobes got be %b dw %b we %b dr %b want 1100 1 0 0", bus.byte_enable, bus.data_write, bus.reg_write_enable, bus.data_read); n_fail++; end
        drive(i_type(6'h24, 5'd2, 16'h0003), 32'h2000, 32'h0);
        n_cmp++; if (bus.reg_data_sel !== 2'b10 || bus.signextend_sel !== 1'b0 || bus.data_read !== 1'b1 || bus.byte_enable !== 4'b1000 || bus.reg_addr_sel !== 2'b00) begin
            $display("FAIL lbu got dsel %b sx %b dr %b be %b asel %b want 10 0 1 1000 00", bus.reg_data_sel, bus.signextend_sel, bus.data_read, bus.byte_enable, bus.reg_addr_sel); n_fail++; end
        drive(i_type(6'h20, 5'd2, 16'hFFFF), 32'h2001, 32'h0);
        n_cmp++; if (bus.alu_result !== 32'h2000 || bus.signextend_sel !== 1'b1 || bus.byte_enable !== 4'b0001) begin $display("FAIL lb got %h sx %b be %b want 2000 1 0001", bus.alu_result, bus.signextend_sel, bus.byte_enable); n_fail++; end
        drive(i_type(6'h23, 5'd2, 16'h0004), 32'h3000, 32'h0);
        n_cmp++; if (bus.reg_data_sel !== 2'b01 || bus.byte_enable !== 4'b1111 || bus.lwlr_sel !== 2'b00) begin $display("FAIL lw got dsel %b be %b lwlr %b want 01 1111 00", bus.reg_data_sel, bus.byte_enable, bus.lwlr_sel); n_fail++; end
        drive(i_type(6'h22, 5'd2, 16'h0001), 32'h3000, 32'h0);
        n_cmp++; if (bus.lwlr_sel !== 2'b11 || bus.reg_data_sel !== 2'b01 || bus.byte_enable !== 4'b1111) begin $display("FAIL lwl got lwlr %b dsel %b be %b want 11 01 1111", bus.lwlr_sel, bus.reg_data_sel, bus.byte_enable); n_fail++; end
        drive(i_type(6'h26, 5'd2, 16'h0002), 32'h3000, 32'h0);
        n_cmp++; if (bus.lwlr_sel !== 2'b10) begin $display("FAIL lwr got lwlr %b want 10", bus.lwlr_sel); n_fail++; end
        drive(i_type(6'h28, 5'd2, 16'h0001), 32'h4000, 32'h0);
        n_cmp++; if (bus.byte_enable !== 4'b0010 || bus.data_write !== 1'b1) begin $display("FAIL sb got be %b dw %b want 0010 1", bus.byte_enable, bus.data_write); n_fail++; end
    endtask

    task automatic test_clk_enable;
        @(negedge clk); drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 32'h3, 32'h4);
        @(posedge clk); #1;
        n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'hC) begin $display("FAIL ce_mult got %h:%h want 0:c", bus.hi, bus.lo); n_fail++; end
        @(negedge clk); bus.clk_enable = 1'b0;
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h1, 32'h1);
        n_cmp++; if (bus.reg_write_enable !== 1'b0 || bus.reg_addr_sel !== 2'b01) begin $display("FAIL ce0_addu got we %b asel %b want 0 01", bus.reg_write_enable, bus.reg_addr_sel); n_fail++; end
        drive(i_type(6'h2B, 5'd2, 16'h0000), 32'h100, 32'h1);
        n_cmp++; if (bus.data_write !== 1'b0) begin $display("FAIL ce0_sw got dw %b want 0", bus.data_write); n_fail++; end
        drive(i_type(6'h23, 5'd2, 16'h0000), 32'h100, 32'h1);
        n_cmp++; if (bus.data_read !== 1'b0 || bus.reg_data_sel !== 2'b01) begin $display("FAIL ce0_lw got dr %b dsel %b want 0 01", bus.data_read, bus.reg_data_sel); n_fail++; end
        drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 32'h5, 32'h5);
        @(posedge clk); #1;
        n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'hC) begin $display("FAIL ce0_hold got %h:%h want 0:c", bus.hi, bus.lo); n_fail++; end
        @(negedge clk); bus.clk_enable = 1'b1;
        drive(32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_async;
        @(negedge clk); drive(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 32'hFFFF_FFFE, 32'h3);
        @(posedge clk); #1;
        drive(32'h0, 32'h0, 32'h0);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin $display("FAIL pre_reset got %h:%h want ffffffff:fffffffa", bus.hi, bus.lo); n_fail++; end
        @(negedge clk); #2; reset = 1'b0; #1;
        n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin $display("FAIL async_reset got %h:%h want 0:0", bus.hi, bus.lo); n_fail++; end
        #1; reset = 1'b1;
    endtask

    initial begin
        bus.clk_enable = 1'b1;
        bus.instr = 32'h0; bus.reg_data_a = 32'h0; bus.reg_data_b = 32'h0;
        test_reset;
        test_alu;
        test_shift_slt;
        test_mult_div;
        test_branch;
        test_jump;
        test_mem;
        test_clk_enable;
        test_reset_async;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
